// File: rtl/sr_rf_pkg.sv
// sr_rf_pkg: default sizes and the pending-write counter update rule (next count plus underflow flag)
package sr_rf_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_CNTW = 2;
  function automatic int unsigned cnt_update(input int unsigned cnt, input logic inc, input logic decw, input logic deck, output logic uf);
    int unsigned up, dn;
    up = cnt + 32'(inc);
    dn = 32'(decw) + 32'(deck);
    uf = up < dn;
    return uf ? 32'd0 : up - dn;
  endfunction
endpackage

// File: rtl/sr_sb_cnt.sv
// sr_sb_cnt: per-register in-flight write counter; i_inc/i_decw/i_deck in, o_cnt current, o_nxt next, o_full saturated, o_uf underflow
module sr_sb_cnt
  import sr_rf_pkg::*;
#(
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_decw,
  input  logic            i_deck,
  output logic [CNTW-1:0] o_cnt,
  output logic [CNTW-1:0] o_nxt,
  output logic            o_full,
  output logic            o_uf
);
  logic [CNTW-1:0] r_cnt;
  int unsigned w_nxt;
  always_comb begin
    o_uf = 1'b0;
    w_nxt = cnt_update(32'(r_cnt), i_inc, i_decw, i_deck, o_uf);
  end
  assign o_nxt = CNTW'(w_nxt);
  assign o_cnt = r_cnt;
  assign o_full = &r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else r_cnt <= o_nxt;
  end
endmodule

// File: rtl/sr_regfile_sb.sv
// sr_regfile_sb: register file with write scoreboard and wb bypass; rd_addr/rd_data/rd_busy read ports, issue_* reserve, wb_* write, kill_* cancel, pend_any/err status
module sr_regfile_sb
  import sr_rf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD = 3,
  parameter int CNTW = DEF_CNTW,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              issue_vld,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  input  logic              wb_vld,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              kill_vld,
  input  logic [AW-1:0]     kill_rd,
  output logic              pend_any,
  output logic              err
);
  logic [XLEN-1:0] r_mem [NREGS];
  logic [CNTW-1:0] w_cnt [NREGS];
  logic [NREGS-1:0] w_inc, w_decw, w_deck, w_full, w_uf, w_nz;
  logic [AW-1:0] w_a;
  logic r_pend, r_err;
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign w_inc[g] = 1'b0;
      assign w_decw[g] = 1'b0;
      assign w_deck[g] = 1'b0;
      assign w_full[g] = 1'b0;
      assign w_uf[g] = 1'b0;
      assign w_nz[g] = 1'b0;
      assign w_cnt[g] = '0;
    end else begin : g_cnt
      logic [CNTW-1:0] w_nxt;
      assign w_inc[g] = issue_vld && issue_ready && issue_rd == AW'(g);
      assign w_decw[g] = wb_vld && wb_rd == AW'(g);
      assign w_deck[g] = kill_vld && kill_rd == AW'(g);
      assign w_nz[g] = |w_nxt;
      sr_sb_cnt #(.CNTW(CNTW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_inc[g]),
        .i_decw (w_decw[g]),
        .i_deck (w_deck[g]),
        .o_cnt  (w_cnt[g]),
        .o_nxt  (w_nxt),
        .o_full (w_full[g]),
        .o_uf   (w_uf[g])
      );
    end
  end
  assign issue_ready = issue_rd == '0 || !w_full[issue_rd] || w_decw[issue_rd] || w_deck[issue_rd];
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_a = '0;
    for (int i = 0; i < NRD; i++) begin
      w_a = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN] = w_a == '0 ? '0 : (wb_vld && wb_rd == w_a) ? wb_data : r_mem[w_a];
      rd_busy[i] = w_a != '0 && {1'b0, w_cnt[w_a]} > (CNTW+1)'(w_decw[w_a]) + (CNTW+1)'(w_deck[w_a]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      r_pend <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (wb_vld && wb_rd != '0) r_mem[wb_rd] <= wb_data;
      r_pend <= |w_nz;
      r_err <= r_err | (|w_uf);
    end
  end
  assign pend_any = r_pend;
  assign err = r_err;
endmodule

// File: tb/tb_sr_regfile_sb.sv
// tb_sr_regfile_sb: directed vector table plus randomized traffic against an integer scoreboard model
module tb_sr_regfile_sb;
  localparam int XLEN = 32, NREGS = 16, NRD = 4, CNTW = 2, AW = 4, CMAX = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic issue_vld = 1'b0, wb_vld = 1'b0, kill_vld = 1'b0;
  logic [AW-1:0] issue_rd = '0, wb_rd = '0, kill_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic issue_ready, pend_any, err;
  always #5 clk = ~clk;
  sr_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_vld(issue_vld), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data),
    .kill_vld(kill_vld), .kill_rd(kill_rd), .pend_any(pend_any), .err(err)
  );
  int checks = 0, errors = 0;
  logic [XLEN-1:0] m_mem [NREGS];
  int m_cnt [NREGS];
  logic m_err, m_pend;
  typedef struct {
    logic r; logic iv; logic [3:0] ir; logic wv; logic [3:0] wr; logic [31:0] wd;
    logic kv; logic [3:0] kr; logic [3:0] a;
    logic [31:0] e_d; logic [3:0] e_b; logic e_rdy; logic e_p; logic e_e;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(logic r, logic iv, logic [3:0] ir, logic wv, logic [3:0] wr, logic [31:0] wd,
                             logic kv, logic [3:0] kr, logic [3:0] a, logic [31:0] e_d, logic [3:0] e_b,
                             logic e_rdy, logic e_p, logic e_e);
    vec_t t;
    t.r = r; t.iv = iv; t.ir = ir; t.wv = wv; t.wr = wr; t.wd = wd; t.kv = kv; t.kr = kr; t.a = a;
    t.e_d = e_d; t.e_b = e_b; t.e_rdy = e_rdy; t.e_p = e_p; t.e_e = e_e;
    return t;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic m_ready();
    return issue_rd == 0 || m_cnt[issue_rd] < CMAX || (wb_vld && wb_rd == issue_rd) || (kill_vld && kill_rd == issue_rd);
  endfunction
  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
    m_pend = 1'b0;
  endtask
  task automatic model_update();
    logic acc;
    int nc;
    acc = issue_vld && m_ready() && issue_rd != 0;
    m_pend = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      nc = m_cnt[r] + ((acc && issue_rd == r) ? 1 : 0) - ((wb_vld && wb_rd == r) ? 1 : 0) - ((kill_vld && kill_rd == r) ? 1 : 0);
      if (nc < 0) begin
        nc = 0;
        m_err = 1'b1;
      end
      m_cnt[r] = nc;
      if (nc != 0) m_pend = 1'b1;
    end
    if (wb_vld && wb_rd != 0) m_mem[wb_rd] = wb_data;
  endtask
  task automatic model_check();
    for (int p = 0; p < NRD; p++) begin
      logic [3:0] a;
      int b;
      a = rd_addr[p*AW +: AW];
      b = m_cnt[a] - ((wb_vld && wb_rd == a) ? 1 : 0) - ((kill_vld && kill_rd == a) ? 1 : 0);
      chk($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], a == 0 ? 32'd0 : (wb_vld && wb_rd == a) ? wb_data : m_mem[a]);
      chk($sformatf("rd_busy[%0d]", p), {31'd0, rd_busy[p]}, (a != 0 && b > 0) ? 32'd1 : 32'd0);
    end
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, m_ready()});
    chk("pend_any", {31'd0, pend_any}, {31'd0, m_pend});
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask
  task automatic drive(input logic r, input logic iv, input logic [3:0] ir, input logic wv, input logic [3:0] wr,
                       input logic [31:0] wd, input logic kv, input logic [3:0] kr, input logic [15:0] ra);
    rst = r; issue_vld = iv; issue_rd = ir; wb_vld = wv; wb_rd = wr; wb_data = wd;
    kill_vld = kv; kill_rd = kr; rd_addr = ra;
    #2;
    if (!r) model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
  endtask
  initial begin
    model_reset();
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 32'hDEADBEEF, 0, 1, 1, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 7, 0, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 7, 0, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 1, 7, 0, 0, 0, 0, 0, 7, 0, 4'hf, 0, 1, 0));
    tv.push_back(v(0, 1, 7, 1, 7, 32'h11111111, 0, 0, 7, 32'h11111111, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 0, 7, 0, 0, 0, 0, 0, 7, 32'h11111111, 4'hf, 0, 1, 0));
    tv.push_back(v(0, 0, 0, 1, 7, 32'h22222222, 0, 0, 7, 32'h22222222, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 0, 0, 1, 7, 32'h33333333, 0, 0, 7, 32'h33333333, 4'hf, 1, 1, 0));
    tv.push_back(v(0, 0, 0, 1, 7, 32'h44444444, 0, 0, 7, 32'h44444444, 0, 1, 1, 0));
    tv.push_back(v(0, 1, 9, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 1, 9, 32'h0000ABCD, 0, 0, 9, 32'h0000ABCD, 0, 1, 1, 0));
    tv.push_back(v(0, 1, 9, 0, 0, 0, 0, 0, 9, 32'h0000ABCD, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 1, 9, 9, 32'h0000ABCD, 0, 1, 1, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h0000ABCD, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 1, 12, 32'h12121212, 0, 0, 12, 32'h12121212, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h12121212, 0, 1, 0, 1));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h12121212, 0, 1, 0, 1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 1, 3, 32'h00000033, 0, 0, 3, 32'h00000033, 0, 1, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h00000033, 0, 1, 0, 1));
    tv.push_back(v(0, 1, 4, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0, 1));
    tv.push_back(v(0, 1, 4, 0, 0, 0, 0, 0, 4, 0, 4'hf, 1, 1, 1));
    tv.push_back(v(0, 0, 0, 1, 4, 32'h00000044, 1, 4, 4, 32'h00000044, 0, 1, 1, 1));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h00000044, 0, 1, 0, 1));
    foreach (tv[k]) begin
      drive(tv[k].r, tv[k].iv, tv[k].ir, tv[k].wv, tv[k].wr, tv[k].wd, tv[k].kv, tv[k].kr, {4{tv[k].a}});
      if (!tv[k].r) begin
        chk($sformatf("vec%0d rd_data[1]", k), rd_data[63:32], tv[k].e_d);
        chk($sformatf("vec%0d rd_busy", k), {28'd0, rd_busy}, {28'd0, tv[k].e_b});
        chk($sformatf("vec%0d issue_ready", k), {31'd0, issue_ready}, {31'd0, tv[k].e_rdy});
        chk($sformatf("vec%0d pend_any", k), {31'd0, pend_any}, {31'd0, tv[k].e_p});
        chk($sformatf("vec%0d err", k), {31'd0, err}, {31'd0, tv[k].e_e});
      end
      tick();
    end
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ra;
      for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 35, 4'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 15, 4'($urandom_range(0, 7)), ra);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
